// File: rtl/hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_pkg                                                         |
// | Opcodes, sequencer state encoding and source-operand decode shared |
// | by the stall/flush sequencer and its hazard comparators.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_STALL2 = 1'b1
  } state_t;

  typedef struct packed {
    logic usesRs;
    logic usesRt;
  } src_use_t;

  // Which register fields of the instruction in IF/ID are actually read.
  function automatic src_use_t decodeSrc(input logic [5:0] opcode);
    src_use_t u;
    u.usesRs = 1'b0;
    u.usesRt = 1'b0;
    case (opcode)
      OP_RTYPE, OP_SW, OP_BEQ: begin
        u.usesRs = 1'b1;
        u.usesRt = 1'b1;
      end
      OP_LW, OP_ADDI: begin
        u.usesRs = 1'b1;
      end
      default: begin
        u.usesRs = 1'b0;
        u.usesRt = 1'b0;
      end
    endcase
    return u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_match                                                       |
// | Flags when a producer destination register is read by the          |
// | instruction in IF/ID. $zero never counts as a dependency.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hazard_match
  import hazard_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] dest,
  output logic       match
);

  src_use_t w_use;

  assign w_use = decodeSrc(opcode);

  // Dependency exists when a read field equals a non-zero destination.
  assign match = (dest != 5'd0) &&
                 ((w_use.usesRs && (rs == dest)) ||
                  (w_use.usesRt && (rt == dest)));

endmodule
`default_nettype wire

// File: rtl/stall_flush_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stall_flush_sequencer                                              |
// | Decode-stage hazard sequencer: picks a 0/1/2-cycle stall for       |
// | ID-resolved branches and load-use, flushes IF/ID on a taken branch |
// | and counts bubble cycles in a saturating counter.                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module stall_flush_sequencer
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dest,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             branch_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic             state
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_matchEx;
  logic             w_matchMem;
  logic             w_isBeq;
  logic [1:0]       w_stallLen;
  logic             w_stall;
  logic             w_flush;
  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_stallCount;

  hazard_match u_matchEx (
    .opcode (id_opcode),
    .rs     (id_rs),
    .rt     (id_rt),
    .dest   (ex_dest),
    .match  (w_matchEx)
  );

  hazard_match u_matchMem (
    .opcode (id_opcode),
    .rs     (id_rs),
    .rt     (id_rt),
    .dest   (mem_dest),
    .match  (w_matchMem)
  );

  assign w_isBeq = (id_opcode == OP_BEQ);

  // Stall length needed by the IF/ID instruction, strongest rule first.
  always_comb begin
    w_stallLen = 2'd0;
    if (id_valid) begin
      if (ex_mem_read && w_matchEx && w_isBeq) begin
        w_stallLen = 2'd2;
      end else if (ex_mem_read && w_matchEx) begin
        w_stallLen = 2'd1;
      end else if (ex_reg_write && !ex_mem_read && w_matchEx && w_isBeq) begin
        w_stallLen = 2'd1;
      end else if (mem_mem_read && w_matchMem && w_isBeq) begin
        w_stallLen = 2'd1;
      end
    end
  end

  // Sequencer state register; reset aborts any stall in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and stall/flush decisions; a stall suppresses the flush
  // because the branch compared stale operands.
  always_comb begin
    w_stateNext = r_state;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_stall = (w_stallLen != 2'd0);
        if (w_stallLen == 2'd2) begin
          w_stateNext = ST_STALL2;
        end
      end
      ST_STALL2: begin
        w_stall     = 1'b1;
        w_stateNext = ST_RUN;
      end
      default: begin
        w_stateNext = ST_RUN;
      end
    endcase
    w_flush = branch_taken && id_valid && !w_stall;
    if (rst) begin
      w_stall = 1'b0;
      w_flush = 1'b0;
    end
  end

  assign pc_hold     = w_stall;
  assign ifid_hold   = w_stall;
  assign idex_bubble = w_stall;
  assign ifid_flush  = w_flush;
  assign state       = r_state;

  // Bubble-cycle counter that sticks at its maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCount <= '0;
    end else if (w_stall && (r_stallCount != c_CNT_MAX)) begin
      r_stallCount <= r_stallCount + c_CNT_ONE;
    end
  end

  assign stall_count = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_stall_flush_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stall_flush_sequencer                                           |
// | Directed scoreboard bench for the stall/flush sequencer.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_stall_flush_sequencer;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic             pcHold;
    logic             ifidHold;
    logic             bubble;
    logic             flush;
    logic             st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       ex_dest;
  logic             mem_mem_read;
  logic [4:0]       mem_dest;
  logic             branch_taken;
  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [CNT_W-1:0] stall_count;
  logic             state;

  exp_t  expQ[$];
  string nameQ[$];
  int    compared   = 0;
  int    mismatched = 0;
  event  sampleNow;

  stall_flush_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_dest      (ex_dest),
    .mem_mem_read (mem_mem_read),
    .mem_dest     (mem_dest),
    .branch_taken (branch_taken),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .stall_count  (stall_count),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic exRw, input logic exMr,
                       input logic [4:0] exD, input logic memMr, input logic [4:0] memD,
                       input logic bt);
    id_valid     = v;
    id_opcode    = op;
    id_rs        = rs;
    id_rt        = rt;
    ex_reg_write = exRw;
    ex_mem_read  = exMr;
    ex_dest      = exD;
    mem_mem_read = memMr;
    mem_dest     = memD;
    branch_taken = bt;
  endtask

  task automatic expectOut(input string nm, input logic s, input logic f,
                           input logic st, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.pcHold   = s;
    e.ifidHold = s;
    e.bubble   = s;
    e.flush    = f;
    e.st       = st;
    e.cnt      = cnt;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per sample point and compares.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk or sampleNow);
      if (expQ.size() > 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        a  = {pc_hold, ifid_hold, idex_bubble, ifid_flush, state, stall_count};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL %s: got pc/ifid/bubble=%b%b%b flush=%b state=%b count=%0d, required pc/ifid/bubble=%b%b%b flush=%b state=%b count=%0d",
                   nm, a.pcHold, a.ifidHold, a.bubble, a.flush, a.st, a.cnt,
                   e.pcHold, e.ifidHold, e.bubble, e.flush, e.st, e.cnt);
        end
      end
    end
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    expectOut("reset", 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // lw $s1 in EX, add rs=23 rt=20 in ID: independent
    drive(1, 6'h00, 23, 20, 1, 1, 17, 0, 0, 0);
    expectOut("lw_add", 0, 0, 0, 0);
    nextCycle();

    // lw $s1 in EX, beq rs=17 rt=18: two stall cycles
    drive(1, 6'h04, 17, 18, 1, 1, 17, 0, 0, 0);
    expectOut("lw_beq_c1", 1, 0, 0, 0);
    nextCycle();
    expectOut("lw_beq_c2", 1, 0, 1, 1);
    nextCycle();
    drive(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    expectOut("after_n2", 0, 0, 0, 2);
    nextCycle();

    // ALU writer of $17 in EX, beq reads it: one stall cycle
    drive(1, 6'h04, 17, 18, 1, 0, 17, 0, 0, 0);
    expectOut("alu_beq", 1, 0, 0, 2);
    nextCycle();
    drive(1, 6'h04, 17, 18, 0, 0, 0, 0, 17, 0);
    expectOut("alu_beq_mem", 0, 0, 0, 3);
    nextCycle();

    // lw $17 in EX, sw rs=17 rt=23: load-use
    drive(1, 6'h2B, 17, 23, 1, 1, 17, 0, 0, 0);
    expectOut("lw_sw", 1, 0, 0, 3);
    nextCycle();
    drive(1, 6'h2B, 17, 23, 1, 1, 0, 0, 0, 0);
    expectOut("lw_sw_dest0", 0, 0, 0, 4);
    nextCycle();

    // taken beq without hazard: single-cycle flush
    drive(1, 6'h04, 17, 18, 0, 0, 0, 0, 0, 1);
    expectOut("beq_flush", 0, 1, 0, 4);
    nextCycle();
    drive(1, 6'h04, 17, 18, 0, 0, 0, 0, 0, 0);
    expectOut("flush_one", 0, 0, 0, 4);
    nextCycle();

    // taken beq during a 2-cycle stall: flush suppressed, then reset mid-stall
    drive(1, 6'h04, 17, 18, 1, 1, 17, 0, 0, 1);
    expectOut("n2_bt_c1", 1, 0, 0, 4);
    nextCycle();
    expectOut("n2_bt_c2", 1, 0, 1, 5);
    @(negedge clk);
    #1;
    rst = 1'b1;
    expectOut("rst_in_stall", 0, 0, 0, 0);
    #1;
    ->sampleNow;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    expectOut("post_rst", 0, 0, 0, 0);
    nextCycle();

    // load of $17 now in MEM, beq reads it: one stall cycle
    drive(1, 6'h04, 17, 18, 0, 0, 0, 1, 17, 0);
    expectOut("mem_load_beq", 1, 0, 0, 0);
    nextCycle();

    // continuous load-use to drive the counter to saturation
    drive(1, 6'h2B, 17, 23, 1, 1, 17, 0, 0, 0);
    expectOut("sat_start", 1, 0, 0, 1);
    repeat (70000) @(posedge clk);
    #1;
    expectOut("sat_end", 1, 0, 0, 16'hFFFF);
    nextCycle();
    drive(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    expectOut("sat_hold", 0, 0, 0, 16'hFFFF);
    nextCycle();

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations never sampled, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
